accum_seq_ctrl: RTL and testbench

Controller that sequences one accumulator datapath instance, the Accum-style block with `in`, `en`, `reset` and `out`, through a full self-check run.
- Holds the DUT in reset for a programmed number of cycles.
- Streams stimulus words from an external stimulus memory into it, one per cycle.
- Compares the DUT output against an external gold memory every cycle.
- Reports pass/fail, mismatch count and first failing index.
- Sits between the testbench top (memories loaded by $readmemh) and the accumulator.

---
 rtl/accum_seq_ctrl.sv | 93 +++++++++
 tb/tb_accum_seq_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/accum_seq_ctrl.sv
// accum_seq_ctrl: sequences an accumulator DUT through reset, stimulus streaming and per-cycle gold compare.
// Optional macro ACCUM_SEQ_STOP_ON_FAIL_EN ends the run on the first mismatch.
module accum_seq_ctrl #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 256,
  parameter int AW           = $clog2(DEPTH + 1),
  parameter int RESET_CYCLES = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  output logic [AW-1:0]    stim_addr,
  input  logic [WIDTH-1:0] stim_data,
  output logic [AW-1:0]    gold_addr,
  input  logic [WIDTH-1:0] gold_data,
  output logic             dut_reset,
  output logic             dut_en,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      mismatch_count,
  output logic [AW-1:0]    first_fail_idx
);
  typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;
  state_t        state_q;
  logic [AW-1:0] idx_q, ffi_q, idx_d;
  logic [4:0]    rcnt_q;
  logic [15:0]   mm_q, mm_d;
  logic          failed_q;
  logic          run, last, miss;
  always_comb begin
    run            = state_q == RUN;
    last           = idx_q == AW'(DEPTH);
    idx_d          = idx_q + 1'b1;
    mm_d           = mm_q + {15'd0, mm_q != 16'hFFFF};
    stim_addr      = run ? idx_q : '0;
    gold_addr      = stim_addr;
    dut_en         = run && !last;
    dut_in         = dut_en ? stim_data : '0;
    miss           = run && dut_out != gold_data;
    busy           = state_q == RST || run;
    done           = state_q == DONE;
    dut_reset      = state_q == IDLE || state_q == RST;
    pass           = done && mm_q == 16'd0;
    mismatch_count = mm_q;
    first_fail_idx = ffi_q;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rcnt_q   <= '0;
      mm_q     <= '0;
      ffi_q    <= '0;
      failed_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q  <= RST;
          rcnt_q   <= 5'(RESET_CYCLES - 1);
          idx_q    <= '0;
          mm_q     <= '0;
          ffi_q    <= '0;
          failed_q <= 1'b0;
        end
        RST: if (abort) state_q <= IDLE;
          else if (rcnt_q == 5'd0) begin
            state_q <= RUN;
            idx_q   <= '0;
          end else rcnt_q <= rcnt_q - 5'd1;
        RUN: if (abort) state_q <= IDLE;
          else begin
            if (miss) begin
              mm_q <= mm_d;
              if (!failed_q) begin
                ffi_q    <= idx_q;
                failed_q <= 1'b1;
              end
            end
`ifdef ACCUM_SEQ_STOP_ON_FAIL_EN
            if (last || miss) state_q <= DONE;
`else
            if (last) state_q <= DONE;
`endif
            else idx_q <= idx_d;
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_accum_seq_ctrl.sv
// tb_accum_seq_ctrl: directed checks of accum_seq_ctrl driving a behavioural accumulator (DEPTH=4).
module tb_accum_seq_ctrl;
  localparam int W = 32, D = 4, AW = 3;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [AW-1:0] stim_addr, gold_addr, first_fail_idx;
  logic [W-1:0] stim_data, gold_data, dut_in, acc;
  logic dut_reset, dut_en, busy, done, pass;
  logic [15:0] mismatch_count;
  logic [W-1:0] stim [0:D-1];
  logic [W-1:0] gold [0:D];
  int total = 0, bad = 0, rc, rn, exp_rn;
  always #5 clk = ~clk;
  assign stim_data = stim_addr < AW'(D) ? stim[stim_addr] : '0;
  assign gold_data = gold[gold_addr];
  always @(posedge clk)
    if (dut_reset) acc <= '0;
    else if (dut_en) acc <= acc + dut_in;
  accum_seq_ctrl #(.WIDTH(W), .DEPTH(D), .AW(AW), .RESET_CYCLES(3)) dut (
    .clock(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .stim_addr(stim_addr), .stim_data(stim_data), .gold_addr(gold_addr), .gold_data(gold_data),
    .dut_reset(dut_reset), .dut_en(dut_en), .dut_in(dut_in), .dut_out(acc),
    .busy(busy), .done(done), .pass(pass), .mismatch_count(mismatch_count),
    .first_fail_idx(first_fail_idx)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [W-1:0] s0, s1, s2, s3, g0, g1, g2, g3, g4);
    stim[0] = s0; stim[1] = s1; stim[2] = s2; stim[3] = s3;
    gold[0] = g0; gold[1] = g1; gold[2] = g2; gold[3] = g3; gold[4] = g4;
  endtask
  task automatic do_run(input bit sb);
    rc = 0;
    rn = 0;
    start = 1'b1;
    step();
    start = sb;
    chk("clr_mm", mismatch_count, 0);
    chk("clr_ffi", first_fail_idx, 0);
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      if (busy && dut_reset) rc++;
      if (busy && !dut_reset) rn++;
      step();
    end
    start = 1'b0;
    chk("timeout_done", done, 1);
  endtask
  initial begin
    load(1, 2, 3, 4, 0, 1, 3, 6, 10);
    step();
    step();
    chk("rst_dut_reset", dut_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mm", mismatch_count, 0);
    chk("rst_addr", stim_addr, 0);
    reset_n = 1'b1;
    step();
    do_run(1'b0);
    chk("nom_rc", rc, 3);
    chk("nom_rn", rn, 5);
    chk("nom_pass", pass, 1);
    chk("nom_mm", mismatch_count, 0);
    chk("nom_ffi", first_fail_idx, 0);
    chk("nom_busy", busy, 0);
    chk("nom_dut_reset", dut_reset, 0);
    step();
    chk("nom_hold", done, 1);
    gold[2] = 4;
    do_run(1'b0);
`ifdef ACCUM_SEQ_STOP_ON_FAIL_EN
    exp_rn = 3;
`else
    exp_rn = 5;
`endif
    chk("gerr_rn", rn, exp_rn);
    chk("gerr_mm", mismatch_count, 1);
    chk("gerr_ffi", first_fail_idx, 2);
    chk("gerr_pass", pass, 0);
    load(1, 2, 3, 4, 5, 5, 5, 5, 5);
    do_run(1'b0);
`ifdef ACCUM_SEQ_STOP_ON_FAIL_EN
    chk("all_mm", mismatch_count, 1);
`else
    chk("all_mm", mismatch_count, 5);
`endif
    chk("all_ffi", first_fail_idx, 0);
    chk("all_pass", pass, 0);
    load(32'hFFFF_FFFF, 2, 0, 0, 0, 32'hFFFF_FFFF, 1, 1, 1);
    do_run(1'b0);
    chk("wrap_pass", pass, 1);
    chk("wrap_mm", mismatch_count, 0);
    load(1, 2, 3, 4, 0, 1, 3, 6, 10);
    gold[3] = 7;
    do_run(1'b0);
    chk("pre_busy_mm", mismatch_count, 1);
    gold[3] = 6;
    do_run(1'b1);
    chk("sb_rc", rc, 3);
    chk("sb_rn", rn, 5);
    chk("sb_pass", pass, 1);
    step();
    chk("sb_no_restart", done, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("ab_k1", stim_addr, 1);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_dut_reset", dut_reset, 1);
    chk("ab_mm", mismatch_count, 0);
    step();
    chk("ab_idle", busy, 0);
    do_run(1'b0);
    chk("ab_rerun_rn", rn, 5);
    chk("ab_rerun_pass", pass, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("ar_k3", stim_addr, 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_dut_reset", dut_reset, 1);
    chk("ar_busy", busy, 0);
    chk("ar_en", dut_en, 0);
    chk("ar_addr", stim_addr, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("ar_idle_done", done, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
